corelet_ctrl: RTL and testbench

Sequencer that drives the corelet's 12-bit in_ctrl word and the activation/weight SRAM (xmem) and partial-sum SRAM (pmem) control pins. For each of num_kij kernel positions it loads weights, streams activations, and drains the OFIFO into pmem. It then accumulates every output pixel across all kernel positions through the SFP path (sfp_sel=1). It is the initiator side of the corelet control interface.

---
 rtl/corelet_ctrl_pkg.sv | 40 ++++
 rtl/corelet_ctrl_cnt.sv | 29 ++
 rtl/corelet_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_corelet_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/corelet_ctrl_pkg.sv
// Shared state encoding, in_ctrl field map and inst_w encodings
// for the corelet control sequencer.
package corelet_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WLOAD,
        S_WFLUSH,
        S_WKER,
        S_WWAIT,
        S_ALOAD,
        S_AFLUSH,
        S_EXEC,
        S_EWAIT,
        S_DRAIN,
        S_ARST,
        S_ARD,
        S_ARELU,
        S_DONE
    } state_t;

    localparam int IC_W          = 12;
    localparam int IC_INST_W_LSB = 0;
    localparam int IC_L0_WR      = 2;
    localparam int IC_L0_RD      = 3;
    localparam int IC_OFIFO_RD   = 6;
    localparam int IC_ACC        = 7;
    localparam int IC_RELU       = 8;
    localparam int IC_SFP_RST    = 10;
    localparam int IC_SFP_SEL    = 11;

    localparam logic [1:0] INST_W_NONE  = 2'b00;
    localparam logic [1:0] INST_W_KLOAD = 2'b01;
    localparam logic [1:0] INST_W_EXEC  = 2'b10;

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/corelet_ctrl_cnt.sv
// Loadable up-counter that wraps to zero on its terminal count.
// tc is combinational so the owner can act on the final step.
module ctrl_cnt
    import corelet_ctrl_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    input  logic [W-1:0] last_val,
    output logic [W-1:0] cnt,
    output logic         tc
);

    assign tc = (cnt == last_val);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (en)
            cnt <= tc ? '0 : cnt + W'(1);
    end

endmodule

// File: rtl/corelet_ctrl.sv
// Corelet sequencer: weight load, activation stream, OFIFO drain, SFP accumulate.
// Define CTRL_RELU_EN to drive in_ctrl[8] during the ARELU step.
module corelet_ctrl
    import corelet_ctrl_pkg::*;
#(
    parameter int row     = 8,
    parameter int col     = 8,
    parameter int len_nij = 16,
    parameter int num_kij = 9,
    parameter int xmem_aw = 11,
    parameter int pmem_aw = 11,
    parameter int A_BASE  = 0,
    parameter int W_BASE  = 1024
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       ofifo_valid,
    output logic [IC_W-1:0]            in_ctrl,
    output logic                       xmem_cen,
    output logic                       xmem_wen,
    output logic [xmem_aw-1:0]         xmem_addr,
    output logic                       pmem_cen,
    output logic                       pmem_wen,
    output logic [pmem_aw-1:0]         pmem_addr,
    output logic                       busy,
    output logic                       done,
    output logic                       out_valid,
    output logic [$clog2(len_nij)-1:0] out_idx
);

    localparam int SMAX = imax(imax(row, row + col), imax(len_nij, num_kij));
    localparam int SW   = $clog2(SMAX + 1);
    localparam int KW   = $clog2(num_kij + 1);
    localparam int OW   = $clog2(len_nij);

    state_t st;

    logic [SW-1:0] step, step_last;
    logic [KW-1:0] kij;
    logic [OW-1:0] o;
    logic          step_en, step_tc;
    logic          kij_en, kij_tc;
    logic          o_en, o_tc;
    logic          run_start;

    logic [IC_W-1:0]    ctrl_d;
    logic               xrd_d, prd_d, pwr_d, arelu_d;
    logic [xmem_aw-1:0] xaddr_d;
    logic [pmem_aw-1:0] paddr_d;
    logic               busy_d, done_d;
    logic               arelu_q;
    logic [OW-1:0]      arelu_idx;

    assign run_start = (st == S_IDLE) && start;
    assign kij_en    = (st == S_DRAIN) && ofifo_valid && step_tc;
    assign o_en      = (st == S_ARELU);

    always_comb begin
        step_en = 1'b0;
        unique case (st)
            S_WLOAD, S_WKER, S_WWAIT,
            S_ALOAD, S_EXEC, S_EWAIT,
            S_ARD:   step_en = 1'b1;
            S_DRAIN: step_en = ofifo_valid;
            default: step_en = 1'b0;
        endcase
    end

    always_comb begin
        step_last = '0;
        unique case (st)
            S_WLOAD, S_WKER:         step_last = SW'(row - 1);
            S_WWAIT, S_EWAIT:        step_last = SW'(row + col - 1);
            S_ALOAD, S_EXEC, S_DRAIN: step_last = SW'(len_nij - 1);
            S_ARD:                   step_last = SW'(num_kij - 1);
            default:                 step_last = '0;
        endcase
    end

    ctrl_cnt #(.W(SW)) u_step (
        .clk      (clk),
        .rst      (reset),
        .load     (run_start),
        .load_val ('0),
        .en       (step_en),
        .last_val (step_last),
        .cnt      (step),
        .tc       (step_tc)
    );

    ctrl_cnt #(.W(KW)) u_kij (
        .clk      (clk),
        .rst      (reset),
        .load     (run_start),
        .load_val ('0),
        .en       (kij_en),
        .last_val (KW'(num_kij - 1)),
        .cnt      (kij),
        .tc       (kij_tc)
    );

    ctrl_cnt #(.W(OW)) u_o (
        .clk      (clk),
        .rst      (reset),
        .load     (run_start),
        .load_val ('0),
        .en       (o_en),
        .last_val (OW'(len_nij - 1)),
        .cnt      (o),
        .tc       (o_tc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st <= S_IDLE;
        end else begin
            unique case (st)
                S_IDLE:   if (start) st <= S_WLOAD;
                S_WLOAD:  if (step_tc) st <= S_WFLUSH;
                S_WFLUSH: st <= S_WKER;
                S_WKER:   if (step_tc) st <= S_WWAIT;
                S_WWAIT:  if (step_tc) st <= S_ALOAD;
                S_ALOAD:  if (step_tc) st <= S_AFLUSH;
                S_AFLUSH: st <= S_EXEC;
                S_EXEC:   if (step_tc) st <= S_EWAIT;
                S_EWAIT:  if (step_tc) st <= S_DRAIN;
                S_DRAIN:  if (kij_en) st <= kij_tc ? S_ARST : S_WLOAD;
                S_ARST:   st <= S_ARD;
                S_ARD:    if (step_tc) st <= S_ARELU;
                S_ARELU:  st <= o_tc ? S_DONE : S_ARST;
                S_DONE:   st <= S_IDLE;
                default:  st <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        ctrl_d  = '0;
        xrd_d   = 1'b0;
        xaddr_d = '0;
        prd_d   = 1'b0;
        pwr_d   = 1'b0;
        paddr_d = '0;
        arelu_d = 1'b0;
        unique case (st)
            S_WLOAD: begin
                xrd_d   = 1'b1;
                xaddr_d = xmem_aw'(32'(W_BASE) + 32'(kij) * 32'(row) + 32'(step));
            end
            S_WKER: begin
                ctrl_d[IC_L0_RD] = 1'b1;
                ctrl_d[IC_INST_W_LSB +: 2] = INST_W_KLOAD;
            end
            S_ALOAD: begin
                xrd_d   = 1'b1;
                xaddr_d = xmem_aw'(32'(A_BASE) + 32'(step));
            end
            S_EXEC: begin
                ctrl_d[IC_L0_RD] = 1'b1;
                ctrl_d[IC_INST_W_LSB +: 2] = INST_W_EXEC;
            end
            S_DRAIN: begin
                ctrl_d[IC_OFIFO_RD] = ofifo_valid;
                pwr_d   = ofifo_valid;
                paddr_d = pmem_aw'(32'(kij) * 32'(len_nij) + 32'(step));
            end
            S_ARST: begin
                ctrl_d[IC_SFP_RST] = 1'b1;
                ctrl_d[IC_SFP_SEL] = 1'b1;
            end
            S_ARD: begin
                ctrl_d[IC_SFP_SEL] = 1'b1;
                prd_d   = 1'b1;
                paddr_d = pmem_aw'(32'(step) * 32'(len_nij) + 32'(o));
            end
            S_ARELU: begin
                ctrl_d[IC_SFP_SEL] = 1'b1;
                arelu_d = 1'b1;
`ifdef CTRL_RELU_EN
                ctrl_d[IC_RELU] = 1'b1;
`else
                ctrl_d[IC_RELU] = 1'b0;
`endif
            end
            default: ;
        endcase
    end

    assign busy_d   = (st == S_IDLE) ? start : (st != S_DONE);
    assign done_d   = (st == S_DONE);
    assign xmem_wen = 1'b1;

    // l0_wr and acc follow their memory read by one cycle (read latency).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_ctrl   <= '0;
            xmem_cen  <= 1'b1;
            xmem_addr <= '0;
            pmem_cen  <= 1'b1;
            pmem_wen  <= 1'b1;
            pmem_addr <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            arelu_q   <= 1'b0;
            arelu_idx <= '0;
            out_valid <= 1'b0;
            out_idx   <= '0;
        end else begin
            in_ctrl           <= ctrl_d;
            in_ctrl[IC_L0_WR] <= ~xmem_cen;
            in_ctrl[IC_ACC]   <= ~pmem_cen & pmem_wen;
            xmem_cen  <= ~xrd_d;
            xmem_addr <= xaddr_d;
            pmem_cen  <= ~(prd_d | pwr_d);
            pmem_wen  <= ~pwr_d;
            pmem_addr <= paddr_d;
            busy      <= busy_d;
            done      <= done_d;
            arelu_q   <= arelu_d;
            arelu_idx <= o;
            out_valid <= arelu_q;
            if (arelu_q)
                out_idx <= arelu_idx;
        end
    end

endmodule

// File: tb/tb_corelet_ctrl.sv
// Directed bench for corelet_ctrl: reset checks, full runs with a
// stream monitor, and a table of expected per-run event counts.
module tb_corelet_ctrl;

    localparam int ROW   = 8;
    localparam int COL   = 8;
    localparam int LEN   = 16;
    localparam int NKIJ  = 9;
    localparam int ABASE = 0;
    localparam int WBASE = 1024;
`ifdef CTRL_RELU_EN
    localparam int EXP_RELU = LEN;
`else
    localparam int EXP_RELU = 0;
`endif
    // per kij: WLOAD+flush, WKER, WWAIT, ALOAD+flush, EXEC, EWAIT, DRAIN
    localparam int KIJ_CYC = (ROW + 1) + ROW + (ROW + COL) + (LEN + 1)
                           + LEN + (ROW + COL) + LEN;
    localparam int EXP_CYC = NKIJ * KIJ_CYC + LEN * (NKIJ + 2) + 1;

    localparam int C_IW01 = 0, C_IW10 = 1, C_L0RD = 2, C_XRD = 3;
    localparam int C_L0WR = 4, C_PWR = 5, C_PRD = 6, C_ACC = 7;
    localparam int C_SRST = 8, C_RELU = 9, C_OV = 10, C_DONE = 11;
    localparam int C_SSEL = 12, NC = 13;

    logic        clk = 1'b0;
    logic        reset, start, ofifo_valid;
    logic [11:0] in_ctrl;
    logic        xmem_cen, xmem_wen, pmem_cen, pmem_wen;
    logic [10:0] xmem_addr, pmem_addr;
    logic        busy, done, out_valid;
    logic [3:0]  out_idx;

    always #5 clk = ~clk;

    corelet_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .ofifo_valid (ofifo_valid),
        .in_ctrl     (in_ctrl),
        .xmem_cen    (xmem_cen),
        .xmem_wen    (xmem_wen),
        .xmem_addr   (xmem_addr),
        .pmem_cen    (pmem_cen),
        .pmem_wen    (pmem_wen),
        .pmem_addr   (pmem_addr),
        .busy        (busy),
        .done        (done),
        .out_valid   (out_valid),
        .out_idx     (out_idx)
    );

    typedef struct {
        string name;
        int    idx;
        int    exp;
    } cvec_t;

    typedef struct {
        bit toggle;
        bit poke;
        int exp_cyc;
    } rvec_t;

    cvec_t ctab[NC];
    rvec_t rtab[2];

    int n_chk = 0;
    int n_fail = 0;
    int cnt_a[NC];
    int exp_x[$];
    int exp_pw[$];
    int exp_pr[$];
    int exp_o, acc_since;
    bit mon_en = 1'b0;
    bit toggle = 1'b0;
    logic prev_xrd = 1'b0, prev_prd = 1'b0, prev_valid = 1'b0, prev_busy = 1'b0;
    logic m_pw, m_pr;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ctrl"}, in_ctrl, 0);
        chk({tag, "_xmem_cen"}, xmem_cen, 1);
        chk({tag, "_xmem_wen"}, xmem_wen, 1);
        chk({tag, "_xmem_addr"}, xmem_addr, 0);
        chk({tag, "_pmem_cen"}, pmem_cen, 1);
        chk({tag, "_pmem_wen"}, pmem_wen, 1);
        chk({tag, "_pmem_addr"}, pmem_addr, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_idx"}, out_idx, 0);
    endtask

    task automatic init_expect();
        for (int i = 0; i < NC; i++) cnt_a[i] = 0;
        exp_x.delete();
        exp_pw.delete();
        exp_pr.delete();
        for (int k = 0; k < NKIJ; k++) begin
            for (int i = 0; i < ROW; i++) exp_x.push_back(WBASE + k * ROW + i);
            for (int t = 0; t < LEN; t++) exp_x.push_back(ABASE + t);
            for (int t = 0; t < LEN; t++) exp_pw.push_back(k * LEN + t);
        end
        for (int oo = 0; oo < LEN; oo++)
            for (int k = 0; k < NKIJ; k++) exp_pr.push_back(k * LEN + oo);
        exp_o = 0;
        acc_since = 0;
    endtask

    task automatic do_run(input bit poke, output int ncyc);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        chk("busy_after_start", busy, 1);
        ncyc = 0;
        while (ncyc < 4000) begin
            @(posedge clk); #1;
            ncyc++;
            if (poke && ncyc == 100) start = 1'b1;
            if (poke && ncyc == 101) start = 1'b0;
            if (done === 1'b1) break;
        end
        chk("done_seen", done, 1);
    endtask

    initial forever begin
        @(posedge clk); #1;
        ofifo_valid = toggle ? ~ofifo_valid : 1'b1;
    end

    initial forever begin
        @(negedge clk);
        m_pw = !pmem_cen && !pmem_wen;
        m_pr = !pmem_cen && pmem_wen;
        if (mon_en) begin
            chk("fixed_bits", {in_ctrl[9], in_ctrl[5:4], xmem_wen}, 4'b0001);
            if (!xmem_cen) begin
                cnt_a[C_XRD]++;
                chk("xmem_read_expected", exp_x.size() > 0, 1);
                if (exp_x.size() > 0) chk("xmem_addr", xmem_addr, exp_x.pop_front());
            end
            if (in_ctrl[2] || prev_xrd) chk("l0_wr_lag", in_ctrl[2], prev_xrd);
            if (in_ctrl[7] || prev_prd) chk("acc_lag", in_ctrl[7], prev_prd);
            if (m_pw || in_ctrl[6]) chk("ofifo_rd_eq_pmem_wr", in_ctrl[6], m_pw);
            if (in_ctrl[6]) chk("ofifo_rd_needs_valid", prev_valid, 1);
            if (m_pw) begin
                cnt_a[C_PWR]++;
                chk("pmem_wr_expected", exp_pw.size() > 0, 1);
                if (exp_pw.size() > 0) chk("pmem_wr_addr", pmem_addr, exp_pw.pop_front());
            end
            if (m_pr) begin
                cnt_a[C_PRD]++;
                chk("pmem_rd_expected", exp_pr.size() > 0, 1);
                if (exp_pr.size() > 0) chk("pmem_rd_addr", pmem_addr, exp_pr.pop_front());
            end
            if (m_pw || in_ctrl[1:0] != 2'b00) chk("sfp_sel_off", in_ctrl[11], 0);
            if (in_ctrl[1:0] == 2'b01) cnt_a[C_IW01]++;
            if (in_ctrl[1:0] == 2'b10) cnt_a[C_IW10]++;
            if (in_ctrl[3]) cnt_a[C_L0RD]++;
            if (in_ctrl[2]) cnt_a[C_L0WR]++;
            if (in_ctrl[8]) cnt_a[C_RELU]++;
            if (in_ctrl[11]) cnt_a[C_SSEL]++;
            if (out_valid) begin
                cnt_a[C_OV]++;
                chk("out_idx", out_idx, exp_o);
                chk("acc_per_output", acc_since, NKIJ);
                exp_o++;
            end
            if (in_ctrl[10]) begin
                cnt_a[C_SRST]++;
                chk("sfp_rst_with_sel", in_ctrl[11], 1);
                acc_since = 0;
            end
            if (in_ctrl[7]) begin
                cnt_a[C_ACC]++;
                acc_since++;
            end
            if (done) begin
                cnt_a[C_DONE]++;
                chk("busy_low_at_done", busy, 0);
                chk("busy_high_before_done", prev_busy, 1);
            end
        end
        prev_xrd   = !xmem_cen;
        prev_prd   = m_pr;
        prev_valid = ofifo_valid;
        prev_busy  = busy;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout, expected test end");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int ncyc;
        ctab[0]  = '{"cnt_inst_w_kload", C_IW01, NKIJ * ROW};
        ctab[1]  = '{"cnt_inst_w_exec",  C_IW10, NKIJ * LEN};
        ctab[2]  = '{"cnt_l0_rd",        C_L0RD, NKIJ * (ROW + LEN)};
        ctab[3]  = '{"cnt_xmem_reads",   C_XRD,  NKIJ * (ROW + LEN)};
        ctab[4]  = '{"cnt_l0_wr",        C_L0WR, NKIJ * (ROW + LEN)};
        ctab[5]  = '{"cnt_pmem_writes",  C_PWR,  NKIJ * LEN};
        ctab[6]  = '{"cnt_pmem_reads",   C_PRD,  NKIJ * LEN};
        ctab[7]  = '{"cnt_acc",          C_ACC,  NKIJ * LEN};
        ctab[8]  = '{"cnt_sfp_reset",    C_SRST, LEN};
        ctab[9]  = '{"cnt_relu",         C_RELU, EXP_RELU};
        ctab[10] = '{"cnt_out_valid",    C_OV,   LEN};
        ctab[11] = '{"cnt_done",         C_DONE, 1};
        ctab[12] = '{"cnt_sfp_sel",      C_SSEL, LEN * (NKIJ + 2)};
        rtab[0]  = '{1'b0, 1'b0, EXP_CYC};
        rtab[1]  = '{1'b1, 1'b1, -1};

        reset = 1'b1;
        start = 1'b0;
        ofifo_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk_reset_vals("por");
        reset = 1'b0;

        // abort a run in EXEC of kij 0
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (55) @(posedge clk);
        #1 chk("inst_w_exec_before_abort", in_ctrl[1:0], 2'b10);
        reset = 1'b1;
        #1 chk_reset_vals("abort");
        @(posedge clk); #1 chk_reset_vals("abort_held");
        reset = 1'b0;

        for (int r = 0; r < 2; r++) begin
            toggle = rtab[r].toggle;
            init_expect();
            mon_en = 1'b1;
            do_run(rtab[r].poke, ncyc);
            if (rtab[r].exp_cyc > 0) chk("cycles_to_done", ncyc, rtab[r].exp_cyc);
            repeat (4) begin
                @(posedge clk); #1;
                chk("idle_after_done", {busy, done}, 2'b00);
            end
            mon_en = 1'b0;
            for (int i = 0; i < NC; i++) chk(ctab[i].name, cnt_a[ctab[i].idx], ctab[i].exp);
            chk("xmem_reads_missing", exp_x.size(), 0);
            chk("pmem_writes_missing", exp_pw.size(), 0);
            chk("pmem_reads_missing", exp_pr.size(), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
